key_dir_ctrl: RTL and testbench
===============================

KEY_DIR_CTRL -- requirements
Module: key_dir_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 500000: consecutive stable cycles needed to accept a key level (10 ms at 50 MHz); minimum 2.
REQ-002 Parameter ACTIVE_LOW, default 1: 1 means raw key is pressed when low; 0 means pressed when high.
REQ-003 Parameter TICK_BASE, default 12500000: move-tick period in cycles at speed 0.
REQ-004 Parameter TICK_STEP, default 1000000: period reduction per speed level.
REQ-005 Parameter TICK_MIN, default 2500000: lower clamp on the move-tick period; minimum 2.
REQ-006 Parameter SPEED_W, default 3: width of the speed input.
REQ-007 CLOCK_50  in  1  sole clock; all state on its rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 key_raw  in  4  unsynchronised keys: [3] up, [2] down, [1] left, [0] right.
REQ-010 restart  in  1  synchronous game restart, active high.
REQ-011 speed  in  SPEED_W  speed level, unsigned.
REQ-012 key_pulse  out  4  one-cycle pulse per debounced press, same bit order as key_raw.
REQ-013 dir  out  2  committed direction: 00 up, 01 down, 10 left, 11 right.
REQ-014 move_tick  out  1  one-cycle pulse at each move step.

Function
REQ-015 Each key SHALL pass a 2-flop synchroniser, then be polarity-normalised per ACTIVE_LOW to "pressed = 1".
REQ-016 Per key, a counter of width clog2(DEB_CYCLES)+1 SHALL increment while the synchronised level differs from the stable level; it clears on any matching cycle.
REQ-017 When the counter reaches DEB_CYCLES-1 while the levels still differ, the stable level SHALL take the synchronised value and the counter SHALL clear.
REQ-018 key_pulse[i] SHALL be high for exactly one cycle, registered, on each 0->1 transition of the stable level; releases SHALL produce no pulse.
REQ-019 Latency SHALL be DEB_CYCLES+3 rising edges from the first edge that samples a held new raw level to key_pulse high.
REQ-020 Any glitch shorter than DEB_CYCLES cycles after synchronisation SHALL produce no pulse.
REQ-021 A pending direction register SHALL capture accepted requests; when several pulses occur in one cycle, priority SHALL be up > down > left > right.
REQ-022 A request for the reverse of the current dir (up/down, left/right) SHALL be rejected; the check is against dir, not against pending.
REQ-023 A request equal to dir SHALL be accepted (no-op). A later accepted request before the next tick SHALL overwrite pending.
REQ-024 dir SHALL load pending only in the cycle move_tick is high, giving at most one turn per move.
REQ-025 A request arriving in the same cycle as move_tick SHALL be checked against the old dir and SHALL update pending only; it takes effect at the following tick.
REQ-026 Period P = max(TICK_BASE - speed*TICK_STEP, TICK_MIN), computed without underflow (saturating at TICK_MIN).
REQ-027 The tick counter SHALL count 0..P-1; move_tick is high when count = P-1, then the count wraps to 0.
REQ-028 speed SHALL be sampled only at wrap; mid-period speed changes SHALL take effect in the next period.
REQ-029 When restart is high, dir and pending SHALL be set to 11, the tick counter to 0, and move_tick to 0 on the next edge.
REQ-030 Restart SHALL take precedence over same-cycle ticks and requests; debounce and synchroniser state SHALL be unaffected by restart.

Reset
REQ-031 While rst_n is low: synchronisers, stable levels (0 = released) and debounce counters SHALL be 0; key_pulse = 0000; dir = 11; pending = 11; tick counter = 0; move_tick = 0; captured P = period for speed 0 after clamp.
REQ-032 Reset assertion mid-debounce or mid-period SHALL abort the operation with no pulse or tick emitted; the first tick after release SHALL follow P cycles later.

Verification (DEB_CYCLES=4, TICK_BASE=20, TICK_STEP=4, TICK_MIN=8, SPEED_W=3, ACTIVE_LOW=1)
REQ-033 Hold key_raw[3] low for 20 cycles -> single key_pulse=1000 exactly 7 edges after first sampling edge; no pulse on release.
REQ-034 Drive 3-cycle low glitches on key_raw[1] -> key_pulse stays 0000.
REQ-035 With dir=11, press left, then up before the tick -> left rejected, pending=00, dir=00 after next move_tick.
REQ-036 speed=0 -> move_tick every 20 cycles; speed=2 -> every 12; speed=7 -> every 8 (clamp); speed change mid-period -> applies to next period only.
REQ-037 Press down and up in the same cycle as move_tick with dir=11 -> pending=00, dir stays 11 until the following tick.
REQ-038 Assert restart mid-period with dir=00 -> next edge dir=11, counter 0, move_tick 20 cycles later; a held key is not re-pulsed.

Source files
------------

// File: rtl/key_dir_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : key_dir_ctrl
//  Purpose  : Debounces four direction keys, turns each debounced press into
//             a one-cycle pulse, filters the requests into a pending turn
//             (no reversals), and commits that turn on a periodic move tick
//             whose period shortens with the speed level.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLOCK_50   in   1        sole clock, rising edge
//    rst_n      in   1        asynchronous reset, active low
//    key_raw    in   4        raw keys: [3] up, [2] down, [1] left, [0] right
//    restart    in   1        synchronous game restart, active high
//    speed      in   SPEED_W  speed level, unsigned
//    key_pulse  out  4        one-cycle pulse per debounced press
//    dir        out  2        committed direction: 00 up 01 down 10 left 11 right
//    move_tick  out  1        one-cycle pulse at each move step
// ============================================================================
module key_dir_ctrl #(
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned ACTIVE_LOW = 1,
  parameter int unsigned TICK_BASE  = 12500000,
  parameter int unsigned TICK_STEP  = 1000000,
  parameter int unsigned TICK_MIN   = 2500000,
  parameter int unsigned SPEED_W    = 3
) (
  input  logic               CLOCK_50,
  input  logic               rst_n,
  input  logic [3:0]         key_raw,
  input  logic               restart,
  input  logic [SPEED_W-1:0] speed,
  output logic [3:0]         key_pulse,
  output logic [1:0]         dir,
  output logic               move_tick
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int unsigned c_DEB_W = $clog2(DEB_CYCLES) + 1;
  localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEB_CYCLES - 1);

  // Longest possible period is the speed-0 period after the clamp.
  localparam int unsigned c_P_MAX = (TICK_BASE > TICK_MIN) ? TICK_BASE : TICK_MIN;
  localparam int unsigned c_TW    = $clog2(c_P_MAX) + 1;
  // Product/difference width: wide enough that speed*TICK_STEP never wraps.
  localparam int unsigned c_PW    = SPEED_W + 32;
  // Largest reduction that still leaves the period above the clamp.
  localparam int unsigned c_HEAD  = (TICK_BASE > TICK_MIN) ? (TICK_BASE - TICK_MIN) : 0;

  localparam logic [1:0] c_DIR_UP    = 2'b00;
  localparam logic [1:0] c_DIR_DOWN  = 2'b01;
  localparam logic [1:0] c_DIR_LEFT  = 2'b10;
  localparam logic [1:0] c_DIR_RIGHT = 2'b11;

  // --------------------------------------------------------------------------
  // Input synchroniser and polarity normalisation
  // --------------------------------------------------------------------------
  // The flops reset to 0; with active-low keys that reads as "pressed" for the
  // two cycles after reset, which the debounce filter absorbs whenever
  // DEB_CYCLES exceeds 2.
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] w_lvl;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_lvl = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

  // --------------------------------------------------------------------------
  // Per-key debounce: the stable level only follows the synchronised level
  // after it has disagreed for DEB_CYCLES consecutive cycles.
  // --------------------------------------------------------------------------
  logic [3:0] w_stable;

  for (genvar gi = 0; gi < 4; gi++) begin : g_deb
    logic [c_DEB_W-1:0] r_cnt;
    logic               r_stable;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt    <= '0;
        r_stable <= 1'b0;
      end else if (w_lvl[gi] != r_stable) begin
        if (r_cnt == c_DEB_LAST) begin
          r_stable <= w_lvl[gi];
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end

    assign w_stable[gi] = r_stable;
  end

  // --------------------------------------------------------------------------
  // Press edge detection (registered): pulse on 0->1 of the stable level only.
  // --------------------------------------------------------------------------
  logic [3:0] r_stable_d;
  logic [3:0] r_pulse;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_stable_d <= 4'b0000;
      r_pulse    <= 4'b0000;
    end else begin
      r_stable_d <= w_stable;
      r_pulse    <= w_stable & ~r_stable_d;
    end
  end

  assign key_pulse = r_pulse;

  // --------------------------------------------------------------------------
  // Request selection and reversal filter
  // --------------------------------------------------------------------------
  logic [1:0] r_dir;
  logic [1:0] r_pend;
  logic [1:0] w_req_dir;
  logic       w_req_vld;
  logic [1:0] w_rev_dir;
  logic       w_accept;

  // The highest-priority pulse is chosen first, then tested for reversal, so
  // a rejected high-priority key masks any lower-priority key in that cycle.
  always_comb begin
    w_req_dir = c_DIR_RIGHT;
    w_req_vld = |r_pulse;
    if (r_pulse[3]) begin
      w_req_dir = c_DIR_UP;
    end else if (r_pulse[2]) begin
      w_req_dir = c_DIR_DOWN;
    end else if (r_pulse[1]) begin
      w_req_dir = c_DIR_LEFT;
    end else begin
      w_req_dir = c_DIR_RIGHT;
    end
  end

  // Reverse pairs differ only in bit 0 (up/down, left/right).
  assign w_rev_dir = {r_dir[1], ~r_dir[0]};
  assign w_accept  = w_req_vld && (w_req_dir != w_rev_dir);

  // --------------------------------------------------------------------------
  // Move-tick period: max(TICK_BASE - speed*TICK_STEP, TICK_MIN) without
  // ever forming a negative intermediate.
  // --------------------------------------------------------------------------
  logic [c_PW-1:0] w_prod;
  logic [c_TW-1:0] w_period_nxt;

  assign w_prod       = c_PW'(speed) * c_PW'(TICK_STEP);
  assign w_period_nxt = (w_prod < c_PW'(c_HEAD)) ? c_TW'(c_PW'(TICK_BASE) - w_prod)
                                                 : c_TW'(TICK_MIN);

  // --------------------------------------------------------------------------
  // Tick counter: counts 0..P-1, P captured only at wrap.
  // --------------------------------------------------------------------------
  logic [c_TW-1:0] r_tcnt;
  logic [c_TW-1:0] r_period;
  logic            w_tick;

  assign w_tick    = (r_tcnt == (r_period - 1'b1));
  assign move_tick = w_tick;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt   <= '0;
      r_period <= c_TW'(c_P_MAX);
    end else if (restart) begin
      r_tcnt <= '0;
    end else if (w_tick) begin
      r_tcnt   <= '0;
      r_period <= w_period_nxt;
    end else begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Pending / committed direction. A request in the tick cycle is judged
  // against the old dir and lands in pending only; dir takes the old pending.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_dir  <= c_DIR_RIGHT;
      r_pend <= c_DIR_RIGHT;
    end else if (restart) begin
      r_dir  <= c_DIR_RIGHT;
      r_pend <= c_DIR_RIGHT;
    end else begin
      if (w_tick) begin
        r_dir <= r_pend;
      end
      if (w_accept) begin
        r_pend <= w_req_dir;
      end
    end
  end

  assign dir = r_dir;

endmodule
`default_nettype wire

// File: tb/tb_key_dir_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_key_dir_ctrl
//  Purpose  : Directed self-checking bench for key_dir_ctrl with small
//             debounce and tick parameters.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_key_dir_ctrl;

  localparam int unsigned c_DEB   = 4;
  localparam int unsigned c_BASE  = 20;
  localparam int unsigned c_STEP  = 4;
  localparam int unsigned c_MIN   = 8;
  localparam int unsigned c_SPW   = 3;

  logic             CLOCK_50 = 1'b0;
  logic             rst_n;
  logic [3:0]       key_raw;
  logic             restart;
  logic [c_SPW-1:0] speed;
  logic [3:0]       key_pulse;
  logic [1:0]       dir;
  logic             move_tick;

  int n_checks = 0;
  int n_fail   = 0;

  key_dir_ctrl #(
    .DEB_CYCLES (c_DEB),
    .ACTIVE_LOW (1),
    .TICK_BASE  (c_BASE),
    .TICK_STEP  (c_STEP),
    .TICK_MIN   (c_MIN),
    .SPEED_W    (c_SPW)
  ) u_dut (
    .CLOCK_50  (CLOCK_50),
    .rst_n     (rst_n),
    .key_raw   (key_raw),
    .restart   (restart),
    .speed     (speed),
    .key_pulse (key_pulse),
    .dir       (dir),
    .move_tick (move_tick)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance negedges until move_tick is seen; n = negedges advanced.
  task automatic next_tick(output int n);
    n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while (move_tick !== 1'b1 && n < 64);
    if (move_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL tick_wait: no move_tick within 64 cycles");
    end
  endtask

  // Watch a window of negedges: count pulses, note first pulse and first tick.
  task automatic watch(input int cycles, output int pulses, output int first_pulse,
                       output logic [3:0] pval, output int first_tick);
    pulses      = 0;
    first_pulse = 0;
    first_tick  = 0;
    pval        = 4'b0000;
    for (int i = 1; i <= cycles; i++) begin
      @(negedge CLOCK_50);
      if (key_pulse != 4'b0000) begin
        pulses++;
        if (first_pulse == 0) begin
          first_pulse = i;
          pval        = key_pulse;
        end
      end
      if (move_tick === 1'b1 && first_tick == 0) first_tick = i;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         np;
    int         fp;
    int         ft;
    int         total;
    logic [3:0] pv;

    rst_n   = 1'b0;
    restart = 1'b0;
    speed   = '0;
    key_raw = 4'hF;
    repeat (3) @(negedge CLOCK_50);
    check("rst_key_pulse", key_pulse, 0);
    check("rst_dir", dir, 3);
    check("rst_move_tick", move_tick, 0);
    rst_n = 1'b1;

    // Tick periods
    next_tick(n);
    next_tick(n);
    check("period_speed0", n, 20);
    speed = 3'd2;
    next_tick(n);
    check("period_speed2", n, 12);
    repeat (3) @(negedge CLOCK_50);
    speed = 3'd7;
    next_tick(n);
    check("period_mid_change", n + 3, 12);
    next_tick(n);
    check("period_speed7_clamp", n, 8);
    speed = 3'd0;
    next_tick(n);
    check("period_back_to_speed0", n, 20);

    // Held press on up: one pulse, 7 edges after the first sampling edge
    key_raw[3] = 1'b0;
    watch(20, np, fp, pv, ft);
    check("up_pulse_count", np, 1);
    check("up_pulse_latency", fp, 7);
    check("up_pulse_value", pv, 4'b1000);
    key_raw[3] = 1'b1;
    watch(12, np, fp, pv, ft);
    check("up_release_no_pulse", np, 0);
    next_tick(n);
    @(negedge CLOCK_50);
    check("dir_up_after_tick", dir, 0);

    // 3-cycle glitches on left are filtered; a 4-cycle press is accepted
    total = 0;
    repeat (4) begin
      key_raw[1] = 1'b0;
      watch(3, np, fp, pv, ft);
      total += np;
      key_raw[1] = 1'b1;
      watch(5, np, fp, pv, ft);
      total += np;
    end
    watch(10, np, fp, pv, ft);
    total += np;
    check("glitch3_no_pulse", total, 0);
    key_raw[1] = 1'b0;
    watch(4, np, fp, pv, ft);
    total = np;
    key_raw[1] = 1'b1;
    watch(12, np, fp, pv, ft);
    total += np;
    check("glitch4_one_pulse", total, 1);

    // Restart mid-period with dir=00 and up held
    key_raw[3] = 1'b0;
    watch(10, np, fp, pv, ft);
    next_tick(n);
    @(negedge CLOCK_50);
    check("dir_before_restart", dir, 0);
    repeat (5) @(negedge CLOCK_50);
    restart = 1'b1;
    @(negedge CLOCK_50);
    restart = 1'b0;
    check("restart_dir", dir, 3);
    check("restart_no_tick", move_tick, 0);
    watch(30, np, fp, pv, ft);
    check("restart_tick_delay", ft + 1, 20);
    check("restart_no_repulse", np, 0);
    check("restart_dir_after_tick", dir, 3);
    key_raw[3] = 1'b1;
    watch(12, np, fp, pv, ft);

    // Left alone is the reverse of right: rejected
    next_tick(n);
    key_raw[1] = 1'b0;
    watch(21, np, fp, pv, ft);
    check("left_pulse_seen", np, 1);
    check("left_rejected_dir", dir, 3);
    key_raw[1] = 1'b1;

    // Left then up before the tick: up wins
    next_tick(n);
    key_raw[1] = 1'b0;
    watch(8, np, fp, pv, ft);
    key_raw[3] = 1'b0;
    watch(12, np, fp, pv, ft);
    check("up_pulse_before_tick", fp, 7);
    check("tick_after_up", ft, 12);
    check("dir_hold_until_tick", dir, 3);
    @(negedge CLOCK_50);
    check("up_overrides_left", dir, 0);
    key_raw[1] = 1'b1;
    key_raw[3] = 1'b1;
    watch(12, np, fp, pv, ft);

    // Down+up pulses in the tick cycle with dir=11
    restart = 1'b1;
    @(negedge CLOCK_50);
    restart = 1'b0;
    repeat (12) @(negedge CLOCK_50);
    key_raw[3] = 1'b0;
    key_raw[2] = 1'b0;
    repeat (7) @(negedge CLOCK_50);
    check("same_cycle_tick", move_tick, 1);
    check("same_cycle_pulse", key_pulse, 4'b1100);
    @(negedge CLOCK_50);
    check("same_cycle_dir_old", dir, 3);
    key_raw[3] = 1'b1;
    key_raw[2] = 1'b1;
    repeat (19) @(negedge CLOCK_50);
    check("second_tick", move_tick, 1);
    @(negedge CLOCK_50);
    check("priority_up_after_tick", dir, 0);

    // Reset during debounce and mid-period
    key_raw[2] = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    rst_n      = 1'b0;
    key_raw[2] = 1'b1;
    #1;
    check("async_rst_dir", dir, 3);
    check("async_rst_pulse", key_pulse, 0);
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    watch(30, np, fp, pv, ft);
    check("rst_tick_delay", ft + 1, 20);
    check("rst_abort_no_pulse", np, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
